// File: rtl/npu_fp_pkg.sv
// Shared definitions for the floating-point dot-product sequencer.
package npu_fp_pkg;

   localparam int FP_W = 32;
   localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

   // Default MAC pipeline depth; the drain counter is sized for depths up to 31.
   localparam int MAC_LAT_DEF = 8;
   localparam int DRAIN_W     = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter that saturates at zero and flags the zero state.
module seq_down_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         areset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   // Load takes priority over decrement; decrementing stops at zero.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   // Zero flag is purely combinational so the FSM can leave a state on the last count.
   assign zero = (count == '0);

endmodule

// File: rtl/fp_mac_seq.sv
// Dot-product sequencer: streams N operand pairs from a buffer into an external
// floating-point MAC, waits out the MAC pipeline and captures the final sum.
module fp_mac_seq
   import npu_fp_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int ADDR_W  = 8,
   parameter int MAC_LAT = MAC_LAT_DEF
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [FP_W-1:0]   rd_a,
   input  logic [FP_W-1:0]   rd_b,
   output logic [FP_W-1:0]   mac_a,
   output logic [FP_W-1:0]   mac_b,
   output logic              mac_en,
   output logic              mac_acc,
   input  logic [FP_W-1:0]   mac_q,
   output logic [FP_W-1:0]   result,
   output logic              result_valid,
   output logic              busy
);

   // DRAIN lasts MAC_LAT cycles starting with the cycle that carries the last element.
   localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(MAC_LAT - 1);

   state_t state_reg;
   state_t state_next;

   logic [ADDR_W-1:0] addr_reg;
   logic              first_pend_reg;
   logic              carry_reg;
   logic              first_reg;
   logic              zero_len_reg;
   logic [FP_W-1:0]   result_reg;
   logic              result_valid_reg;

   logic              accept;
   logic              drain_load;
   logic              drain_dec;
   logic              capture;
   logic [LEN_W-1:0]  elem_init;
   logic [LEN_W-1:0]  elem_cnt;
   logic              elem_zero;
   logic [DRAIN_W-1:0] drain_cnt;
   logic              drain_zero;
   logic              unused_cnt;

   // Element counter holds N-1 so it never needs a value wider than len itself.
   assign elem_init = (len == '0) ? '0 : len - LEN_W'(1);

   seq_down_cnt #(.W(LEN_W)) u_elem_cnt (
      .clk      (clk),
      .areset   (areset),
      .load     (accept),
      .load_val (elem_init),
      .dec      (rd_en),
      .count    (elem_cnt),
      .zero     (elem_zero)
   );

   seq_down_cnt #(.W(DRAIN_W)) u_drain_cnt (
      .clk      (clk),
      .areset   (areset),
      .load     (drain_load),
      .load_val (DRAIN_INIT),
      .dec      (drain_dec),
      .count    (drain_cnt),
      .zero     (drain_zero)
   );

   // Only the zero flags steer the FSM; the raw counts are observation-only.
   assign unused_cnt = ^{elem_cnt, drain_cnt};

   // State register.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: a zero-length request skips straight to DONE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = (len == '0) ? DONE : ISSUE;
         ISSUE:   if (elem_zero) state_next = DRAIN;
         DRAIN:   if (drain_zero) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output and control decode; idle MAC slots feed 0*0 with accumulate set.
   always_comb begin
      busy       = (state_reg != IDLE);
      rd_en      = (state_reg == ISSUE);
      mac_en     = busy;
      accept     = (state_reg == IDLE) && start;
      drain_load = rd_en && elem_zero;
      drain_dec  = (state_reg == DRAIN);
      capture    = (state_reg == DONE);
      mac_acc    = busy && !(carry_reg && first_reg);
      mac_a      = carry_reg ? rd_a : FP_ZERO;
      mac_b      = carry_reg ? rd_b : FP_ZERO;
   end

   // Datapath: address walk, element tracking one cycle behind the read, result capture.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         addr_reg         <= '0;
         first_pend_reg   <= 1'b0;
         carry_reg        <= 1'b0;
         first_reg        <= 1'b0;
         zero_len_reg     <= 1'b0;
         result_reg       <= FP_ZERO;
         result_valid_reg <= 1'b0;
      end else begin
         carry_reg        <= rd_en;
         first_reg        <= rd_en && first_pend_reg;
         result_valid_reg <= capture;
         if (accept) begin
            addr_reg       <= base_addr;
            first_pend_reg <= 1'b1;
            zero_len_reg   <= (len == '0);
         end else if (rd_en) begin
            addr_reg       <= addr_reg + ADDR_W'(1);
            first_pend_reg <= 1'b0;
         end
         if (capture) begin
            result_reg <= zero_len_reg ? FP_ZERO : mac_q;
         end
      end
   end

   assign rd_addr      = addr_reg;
   assign result       = result_reg;
   assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_fp_mac_seq.sv
// Bench for fp_mac_seq: operand buffer, behavioural MAC and a result scoreboard.
module tb_fp_mac_seq;

   localparam int LAT = 8;

   logic        clk = 1'b0;
   logic        areset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic [7:0]  base_addr = '0;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [31:0] rd_a = '0;
   logic [31:0] rd_b = '0;
   logic [31:0] mac_a, mac_b, mac_q;
   logic        mac_en, mac_acc;
   logic [31:0] result;
   logic        result_valid, busy;

   fp_mac_seq #(.LEN_W(8), .ADDR_W(8), .MAC_LAT(LAT)) dut (
      .clk(clk), .areset(areset), .start(start), .len(len), .base_addr(base_addr),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
      .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_acc(mac_acc), .mac_q(mac_q),
      .result(result), .result_valid(result_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int cyc = 0;
   int t0 = 0;
   int rd_cnt = 0;
   int rv_cnt = 0;
   bit prev_rd = 1'b0;
   logic [31:0] exp_q[$];
   logic [7:0]  addr_log[$];
   bit          acc_log[$];

   function automatic real fp2real(input logic [31:0] f);
      real v;
      int  e;
      if (f[30:0] == 31'd0) return 0.0;
      v = 1.0 + real'(f[22:0]) / 8388608.0;
      e = int'(f[30:23]) - 127;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return f[31] ? -v : v;
   endfunction

   function automatic logic [31:0] real2fp(input real r);
      logic        s;
      real         m;
      int          e;
      logic [22:0] man;
      if (r == 0.0) return 32'h0;
      s = (r < 0.0);
      m = s ? -r : r;
      e = 127;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      man = 23'($rtoi((m - 1.0) * 8388608.0));
      return {s, 8'(e), man};
   endfunction

   // Operand buffer with one-cycle read latency.
   logic [31:0] mem_a [0:255];
   logic [31:0] mem_b [0:255];
   always @(posedge clk) begin
      if (rd_en) begin
         rd_a <= mem_a[rd_addr];
         rd_b <= mem_b[rd_addr];
      end
   end

   // Behavioural MAC: accumulator register followed by LAT-1 delay stages.
   real         acc_r = 0.0;
   logic [31:0] acc_bits;
   logic [31:0] dly [1:LAT-1];
   always @(posedge clk) begin
      if (mac_en) begin
         if (mac_acc) acc_r <= acc_r + fp2real(mac_a) * fp2real(mac_b);
         else         acc_r <= fp2real(mac_a) * fp2real(mac_b);
      end
   end
   always @* acc_bits = real2fp(acc_r);
   always @(posedge clk) begin
      dly[1] <= acc_bits;
      for (int i = 2; i < LAT; i++) dly[i] <= dly[i-1];
   end
   assign mac_q = dly[LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: reads, element accumulate flags and result pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (rd_en) begin
         rd_cnt <= rd_cnt + 1;
         addr_log.push_back(rd_addr);
      end
      if (prev_rd) acc_log.push_back(mac_acc);
      prev_rd <= rd_en;
      if (result_valid) rv_cnt <= rv_cnt + 1;
   end

   // Called at a negedge; returns just after the sampling edge.
   task automatic launch(input logic [7:0] n, input logic [7:0] b);
      start = 1'b1;
      len = n;
      base_addr = b;
      @(posedge clk);
      #1;
      t0 = cyc;
      start = 1'b0;
   endtask

   task automatic wait_rv(output int lat, output bit got);
      got = 1'b0;
      lat = -1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (result_valid) begin
            got = 1'b1;
            lat = cyc - t0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      chk_cnt++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rd_en); else pass_cnt++;
      chk_cnt++; if (rd_addr !== 8'h00) $display("FAIL reset_rd_addr: got %h want 00", rd_addr); else pass_cnt++;
      chk_cnt++; if (mac_en !== 1'b0 || mac_acc !== 1'b0) $display("FAIL reset_mac_ctl: got en=%b acc=%b want 0 0", mac_en, mac_acc); else pass_cnt++;
      chk_cnt++; if (result !== 32'h0 || result_valid !== 1'b0) $display("FAIL reset_result: got %h/%b want 00000000/0", result, result_valid); else pass_cnt++;
      areset = 1'b0;
   endtask

   task automatic test_basic();
      int lat; bit got; int rd0, a0, c0; logic [31:0] exp; logic [23:0] addrs; logic [2:0] accs;
      mem_a[8'h10] = real2fp(1.0); mem_b[8'h10] = real2fp(2.0);
      mem_a[8'h11] = real2fp(2.0); mem_b[8'h11] = real2fp(2.0);
      mem_a[8'h12] = real2fp(3.0); mem_b[8'h12] = real2fp(2.0);
      exp_q.push_back(real2fp(1.0 * 2.0 + 2.0 * 2.0 + 3.0 * 2.0));
      rd0 = rd_cnt; a0 = addr_log.size(); c0 = acc_log.size();
      @(negedge clk);
      launch(8'd3, 8'h10);
      wait_rv(lat, got);
      chk_cnt++; if (!got || lat != 3 + LAT + 1) $display("FAIL basic_latency: got %0d want %0d", lat, 3 + LAT + 1); else pass_cnt++;
      exp = exp_q.pop_front();
      chk_cnt++; if (result !== exp) $display("FAIL basic_result: got %h want %h", result, exp); else pass_cnt++;
      chk_cnt++; if (result !== 32'h4140_0000) $display("FAIL basic_result_12: got %h want 41400000", result); else pass_cnt++;
      chk_cnt++; if (rd_cnt - rd0 != 3) $display("FAIL basic_rd_count: got %0d want 3", rd_cnt - rd0); else pass_cnt++;
      addrs = 'x; accs = 'x;
      if (addr_log.size() >= a0 + 3) addrs = {addr_log[a0], addr_log[a0+1], addr_log[a0+2]};
      if (acc_log.size() >= c0 + 3) accs = {acc_log[c0], acc_log[c0+1], acc_log[c0+2]};
      chk_cnt++; if (addrs !== 24'h10_11_12) $display("FAIL basic_addr_seq: got %h want 101112", addrs); else pass_cnt++;
      chk_cnt++; if (accs !== 3'b011) $display("FAIL basic_acc_seq: got %b want 011", accs); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (result_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_pulse_end: got rv=%b busy=%b want 0 0", result_valid, busy); else pass_cnt++;
   endtask

   // Zero length: result_valid appears two cycles after the cycle start is presented in.
   task automatic test_zero_len();
      int lat; bit got; int rd0; logic [31:0] exp;
      exp_q.push_back(32'h0);
      rd0 = rd_cnt;
      @(negedge clk);
      launch(8'd0, 8'h55);
      wait_rv(lat, got);
      chk_cnt++; if (!got || lat != 1) $display("FAIL zero_latency: got %0d want 1", lat); else pass_cnt++;
      exp = exp_q.pop_front();
      chk_cnt++; if (result !== exp) $display("FAIL zero_result: got %h want %h", result, exp); else pass_cnt++;
      chk_cnt++; if (rd_cnt - rd0 != 0) $display("FAIL zero_no_reads: got %0d want 0", rd_cnt - rd0); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int lat; bit got; logic [31:0] exp;
      mem_a[8'h20] = real2fp(2.5); mem_b[8'h20] = real2fp(2.0);
      mem_a[8'h21] = real2fp(1.0); mem_b[8'h21] = real2fp(4.0);
      mem_a[8'h30] = real2fp(4.0); mem_b[8'h30] = real2fp(0.5);
      exp_q.push_back(real2fp(2.5 * 2.0 + 1.0 * 4.0));
      exp_q.push_back(real2fp(4.0 * 0.5));
      @(negedge clk);
      launch(8'd2, 8'h20);
      wait_rv(lat, got);
      exp = exp_q.pop_front();
      chk_cnt++; if (!got || result !== exp) $display("FAIL b2b_first: got %h want %h", result, exp); else pass_cnt++;
      launch(8'd1, 8'h30);
      wait_rv(lat, got);
      chk_cnt++; if (!got || lat != 1 + LAT + 1) $display("FAIL b2b_latency: got %0d want %0d", lat, 1 + LAT + 1); else pass_cnt++;
      exp = exp_q.pop_front();
      chk_cnt++; if (result !== exp) $display("FAIL b2b_second: got %h want %h", result, exp); else pass_cnt++;
      chk_cnt++; if (result !== 32'h4000_0000) $display("FAIL b2b_second_2p0: got %h want 40000000", result); else pass_cnt++;
   endtask

   task automatic test_wrap();
      int lat; bit got; int a0; logic [31:0] exp; logic [31:0] addrs;
      mem_a[8'hFE] = real2fp(1.0); mem_b[8'hFE] = real2fp(1.0);
      mem_a[8'hFF] = real2fp(1.0); mem_b[8'hFF] = real2fp(2.0);
      mem_a[8'h00] = real2fp(1.0); mem_b[8'h00] = real2fp(3.0);
      mem_a[8'h01] = real2fp(1.0); mem_b[8'h01] = real2fp(4.0);
      exp_q.push_back(real2fp(10.0));
      a0 = addr_log.size();
      @(negedge clk);
      launch(8'd4, 8'hFE);
      wait_rv(lat, got);
      addrs = 'x;
      if (addr_log.size() >= a0 + 4) addrs = {addr_log[a0], addr_log[a0+1], addr_log[a0+2], addr_log[a0+3]};
      chk_cnt++; if (addrs !== 32'hFE_FF_00_01) $display("FAIL wrap_addr_seq: got %h want FEFF0001", addrs); else pass_cnt++;
      exp = exp_q.pop_front();
      chk_cnt++; if (!got || result !== exp) $display("FAIL wrap_result: got %h want %h", result, exp); else pass_cnt++;
   endtask

   task automatic test_start_in_drain();
      int lat; bit got; int rd0, rv0; logic [31:0] exp;
      mem_a[8'h40] = real2fp(3.0); mem_b[8'h40] = real2fp(1.0);
      mem_a[8'h41] = real2fp(0.5); mem_b[8'h41] = real2fp(4.0);
      exp_q.push_back(real2fp(5.0));
      rd0 = rd_cnt;
      @(negedge clk);
      launch(8'd2, 8'h40);
      repeat (4) @(negedge clk);
      chk_cnt++; if (busy !== 1'b1 || rd_en !== 1'b0) $display("FAIL drain_state: got busy=%b rd_en=%b want 1 0", busy, rd_en); else pass_cnt++;
      start = 1'b1; len = 8'd6; base_addr = 8'h80;
      @(negedge clk);
      start = 1'b0;
      chk_cnt++; if (result !== 32'h4120_0000) $display("FAIL drain_result_held: got %h want 41200000", result); else pass_cnt++;
      wait_rv(lat, got);
      chk_cnt++; if (!got || lat != 2 + LAT + 1) $display("FAIL drain_latency: got %0d want %0d", lat, 2 + LAT + 1); else pass_cnt++;
      exp = exp_q.pop_front();
      chk_cnt++; if (result !== exp) $display("FAIL drain_result: got %h want %h", result, exp); else pass_cnt++;
      @(negedge clk);
      #1;
      rv0 = rv_cnt;
      repeat (20) @(negedge clk);
      #1;
      chk_cnt++; if (rd_cnt - rd0 != 2) $display("FAIL drain_no_extra_rd: got %0d want 2", rd_cnt - rd0); else pass_cnt++;
      chk_cnt++; if (rv_cnt != rv0 || busy !== 1'b0) $display("FAIL drain_no_extra_run: got rv=%0d busy=%b want %0d 0", rv_cnt, busy, rv0); else pass_cnt++;
   endtask

   task automatic test_reset_mid_issue();
      int lat; bit got; int rv0; logic [31:0] exp;
      mem_a[8'h50] = real2fp(7.0); mem_b[8'h50] = real2fp(7.0);
      mem_a[8'h51] = real2fp(7.0); mem_b[8'h51] = real2fp(7.0);
      mem_a[8'h60] = real2fp(1.5); mem_b[8'h60] = real2fp(2.0);
      @(negedge clk);
      launch(8'd5, 8'h50);
      repeat (2) @(negedge clk);
      #1;
      rv0 = rv_cnt;
      chk_cnt++; if (rd_en !== 1'b1 || busy !== 1'b1) $display("FAIL rst_mid_active: got rd_en=%b busy=%b want 1 1", rd_en, busy); else pass_cnt++;
      areset = 1'b1;
      #1;
      chk_cnt++; if (busy !== 1'b0 || rd_en !== 1'b0 || mac_en !== 1'b0) $display("FAIL rst_mid_ctl: got busy=%b rd_en=%b mac_en=%b want 0 0 0", busy, rd_en, mac_en); else pass_cnt++;
      chk_cnt++; if (rd_addr !== 8'h00 || mac_acc !== 1'b0 || mac_a !== 32'h0) $display("FAIL rst_mid_dp: got addr=%h acc=%b mac_a=%h want 00 0 00000000", rd_addr, mac_acc, mac_a); else pass_cnt++;
      chk_cnt++; if (result !== 32'h0 || result_valid !== 1'b0) $display("FAIL rst_mid_result: got %h/%b want 00000000/0", result, result_valid); else pass_cnt++;
      repeat (2) @(negedge clk);
      areset = 1'b0;
      exp_q.push_back(real2fp(1.5 * 2.0));
      launch(8'd1, 8'h60);
      wait_rv(lat, got);
      chk_cnt++; if (!got || lat != 1 + LAT + 1) $display("FAIL rst_rerun_latency: got %0d want %0d", lat, 1 + LAT + 1); else pass_cnt++;
      exp = exp_q.pop_front();
      chk_cnt++; if (result !== exp) $display("FAIL rst_rerun_result: got %h want %h", result, exp); else pass_cnt++;
      @(negedge clk);
      #1;
      chk_cnt++; if (rv_cnt - rv0 != 1) $display("FAIL rst_no_stale_valid: got %0d pulses want 1", rv_cnt - rv0); else pass_cnt++;
   endtask

   task automatic test_max_len();
      int lat; bit got; int rd0; logic [31:0] exp;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = real2fp(1.0);
         mem_b[i] = real2fp(1.0);
      end
      exp_q.push_back(real2fp(255.0));
      rd0 = rd_cnt;
      @(negedge clk);
      launch(8'd255, 8'h00);
      wait_rv(lat, got);
      chk_cnt++; if (!got || lat != 255 + LAT + 1) $display("FAIL max_latency: got %0d want %0d", lat, 255 + LAT + 1); else pass_cnt++;
      exp = exp_q.pop_front();
      chk_cnt++; if (result !== exp || result !== 32'h437F_0000) $display("FAIL max_result: got %h want %h", result, exp); else pass_cnt++;
      chk_cnt++; if (rd_cnt - rd0 != 255) $display("FAIL max_rd_count: got %0d want 255", rd_cnt - rd0); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_back_to_back();
      test_wrap();
      test_start_in_drain();
      test_reset_mid_issue();
      test_max_len();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fp_mac_seq.md
FP_MAC_SEQ -- requirements
Module: fp_mac_seq

Interface
REQ-001 Parameter LEN_W, default 8: width of the vector-length field.
REQ-002 Parameter ADDR_W, default 8: width of the operand-buffer address.
REQ-003 Parameter MAC_LAT, default 8: cycles from a MAC input to its accumulated q; range 1..31.
REQ-004 clk  in  1: single clock, rising edge.
REQ-005 areset  in  1: reset, asynchronous and active-high.
REQ-006 start  in  1: one-cycle pulse that launches a dot product; sampled only in IDLE.
REQ-007 len  in  LEN_W: element count N, sampled with start.
REQ-008 base_addr  in  ADDR_W: first operand address, sampled with start.
REQ-009 rd_en  out  1: operand-buffer read strobe.
REQ-010 rd_addr  out  ADDR_W: operand-buffer address.
REQ-011 rd_a, rd_b  in  32: IEEE-754 single operands, valid one cycle after rd_en.
REQ-012 mac_a, mac_b  out  32: operands to the fp MAC.
REQ-013 mac_en  out  1: MAC clock enable.
REQ-014 mac_acc  out  1: 0 = load the product, 1 = add the product to the running sum.
REQ-015 mac_q  in  32: MAC accumulated output.
REQ-016 result  out  32: captured dot product, held until the next start.
REQ-017 result_valid  out  1: one-cycle pulse when result updates.
REQ-018 busy  out  1: high in every state other than IDLE.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, DRAIN, DONE.
REQ-020 IDLE->ISSUE on start with N>0; IDLE->DONE on start with N=0.
REQ-021 In ISSUE, rd_en SHALL be high for exactly N consecutive cycles, with rd_addr = base_addr+i for i=0..N-1, wrapping modulo 2^ADDR_W.
REQ-022 The cycle after each rd_en, mac_a/mac_b SHALL equal rd_a/rd_b combinationally, and mac_acc SHALL be 0 for element 0 and 1 for elements 1..N-1.
REQ-023 When not carrying an element, mac_a = mac_b = 0x00000000 and mac_acc = 1, so 0*0 is added harmlessly.
REQ-024 mac_en SHALL be 1 whenever busy, and 0 in IDLE.
REQ-025 ISSUE->DRAIN after the last read; DRAIN SHALL count MAC_LAT cycles from the last MAC input.
REQ-026 DRAIN->DONE: result SHALL capture mac_q exactly MAC_LAT cycles after the last MAC input cycle.
REQ-027 In DONE, result_valid SHALL pulse for one cycle, then the FSM returns to IDLE.
REQ-028 For N>0, result_valid SHALL assert exactly N+MAC_LAT+1 cycles after the start-sampling edge.
REQ-029 For N=0, the block SHALL issue no reads, set result = 0x00000000, and pulse result_valid 2 cycles after start.
REQ-030 start while busy SHALL be ignored; len and base_addr are latched only on an accepted start.
REQ-031 N = 2^LEN_W-1 SHALL work without counter overflow.
REQ-032 The block SHALL perform no floating-point arithmetic; all arithmetic is done by the MAC.

Reset
REQ-033 areset SHALL force, asynchronously: IDLE, busy=0, rd_en=0, rd_addr=0, mac_en=0, mac_acc=0, result=0, result_valid=0, all counters 0.
REQ-034 areset during ISSUE or DRAIN SHALL abandon the operation with no result_valid, and the block SHALL accept a start on the first cycle after release.

Structure
REQ-035 Package npu_fp_pkg SHALL hold FP_W=32, FP_ZERO=32'h0, the default MAC_LAT, and the state enum.
REQ-036 One sub-module, seq_down_cnt (loadable down-counter with zero flag), SHALL be used for both the element count and the drain count.

Verification
REQ-037 N=3, a={1.0,2.0,3.0}, b={2.0,2.0,2.0}, behavioural MAC with LAT=8 -> result=0x41400000 (12.0), result_valid at cycle 12, mac_acc sequence 0,1,1.
REQ-038 N=0 -> no rd_en, result=0x00000000, result_valid 2 cycles after start.
REQ-039 Two back-to-back runs, second with a={4.0}, b={0.5} -> second result=0x40000000, showing that sum load via mac_acc=0 clears the earlier sum.
REQ-040 base_addr=0xFE, N=4 -> rd_addr sequence FE, FF, 00, 01.
REQ-041 start pulsed during DRAIN -> ignored, result unchanged, no extra rd_en.
REQ-042 areset asserted mid-ISSUE (N=5, 2 reads done) -> all outputs 0 immediately, no result_valid; a following run with N=1 completes correctly.
